pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control request/response bundle.
// Handshake: there is no valid/ready pair here; the requests are level
// signals sampled on every rising clk edge, and the stall vector is a
// same-cycle combinational answer to them. flush/new_pc_o form a one-cycle
// pulse: new_pc_o is meaningful only while flush=1.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        flush_req;
  logic [31:0] new_pc_i;
  logic        halt_req;
  logic        resume_req;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc_o;
  logic [1:0]  state_o;
  logic        timeout_o;
  logic [15:0] stall_cnt_o;

  // Requester side (pipeline / bench)
  modport master (
    output stallreq_id, stallreq_ex, flush_req, new_pc_i, halt_req, resume_req,
    input  stall, flush, new_pc_o, state_o, timeout_o, stall_cnt_o
  );

  // Controller side
  modport slave (
    input  stallreq_id, stallreq_ex, flush_req, new_pc_i, halt_req, resume_req,
    output stall, flush, new_pc_o, state_o, timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/halt controller with stall timeout.
// Optional feature: define CTRL_PERF_CNT_EN to build the saturating
// stalled-cycle counter on stall_cnt_o; otherwise stall_cnt_o is 0.
module pipe_ctrl #(
  parameter int          STALL_LIMIT = 64,
  parameter logic [31:0] TIMEOUT_VEC = 32'h0000_0100
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int            CW     = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(STALL_LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(STALL_LIMIT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_new_pc;
  logic          r_timeout;
  logic [CW-1:0] r_to_cnt;
  logic [5:0]    w_stall;
  logic          w_cap_pc;
  logic          w_cap_to;
  logic          w_active;
  logic          w_ex_run;
  logic          w_to_hit;

  // RUN and STALL share request handling; the timeout counter only runs there.
  assign w_active = (r_state == RUN) || (r_state == STALL);
  assign w_ex_run = w_active && bus.stallreq_ex && !bus.flush_req;
  assign w_to_hit = w_ex_run && (r_to_cnt == LIM_M1);

  // Next-state and combinational stall vector, requests in fixed priority.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 6'b000000;
    w_cap_pc    = 1'b0;
    w_cap_to    = 1'b0;
    case (r_state)
      RUN, STALL: begin
        if (bus.flush_req) begin
          w_state_nxt = FLUSH;
          w_cap_pc    = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = FLUSH;
          w_cap_to    = 1'b1;
        end else if (bus.stallreq_ex) begin
          w_state_nxt = STALL;
          w_stall     = 6'b001111;
        end else if (bus.stallreq_id) begin
          w_state_nxt = STALL;
          w_stall     = 6'b000111;
        end else if (bus.halt_req && (r_state == RUN)) begin
          w_state_nxt = HALT;
        end else begin
          w_state_nxt = RUN;
        end
      end
      HALT: begin
        if (bus.flush_req) begin
          w_state_nxt = FLUSH;
          w_cap_pc    = 1'b1;
        end else if (bus.resume_req) begin
          w_state_nxt = RUN;
        end else begin
          w_stall     = 6'b111111;
        end
      end
      default: begin
        // FLUSH: single cycle, every request ignored.
        w_state_nxt = RUN;
      end
    endcase
    if (rst) begin
      w_stall = 6'b000000;
    end
  end

  // State, restart PC, sticky timeout flag and consecutive-stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_new_pc  <= 32'h0;
      r_timeout <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap_pc) begin
        r_new_pc <= bus.new_pc_i;
      end else if (w_cap_to) begin
        r_new_pc  <= TIMEOUT_VEC;
        r_timeout <= 1'b1;
      end
      if (w_ex_run) begin
        if (r_to_cnt != LIM) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles in which any stage is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0;
    end else if ((w_stall != 6'b000000) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
`else
  assign bus.stall_cnt_o = 16'h0;
`endif

  assign bus.stall     = w_stall;
  assign bus.flush     = (r_state == FLUSH);
  assign bus.new_pc_o  = r_new_pc;
  assign bus.state_o   = r_state;
  assign bus.timeout_o = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, timeout sequences, and
// randomized traffic checked against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int LIMIT = 64;

  logic clk;
  logic rst;
  pipe_ctrl_if u_if ();

  pipe_ctrl #(.STALL_LIMIT(LIMIT), .TIMEOUT_VEC(32'h0000_0100)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: mode 0 run, 1 stalled, 2 halted, 3 flushing.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_to;
  int          m_ex_run;    // length of the current stallreq_ex run
  int          m_perf;
  bit          m_valid = 1'b0;

  // Values sampled mid-cycle by the last call of cycle()
  logic [5:0]  s_stall;
  logic        s_flush;
  logic [31:0] s_pc;
  logic [1:0]  s_state;
  logic        s_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_stall(input logic r, id, ex, fl, h, rs);
    if (r) return 6'h00;
    if (m_mode == 3) return 6'h00;
    if (m_mode == 2) return (fl || rs) ? 6'h00 : 6'h3F;
    if (fl) return 6'h00;
    if (ex && (m_ex_run == LIMIT - 1)) return 6'h00;
    if (ex) return 6'h0F;
    if (id) return 6'h07;
    return 6'h00;
  endfunction

  // One clock: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cycle(input logic r, id, ex, fl, input logic [31:0] pc, input logic h, rs);
    logic [5:0] e_stall;
    rst = r;
    u_if.stallreq_id = id;
    u_if.stallreq_ex = ex;
    u_if.flush_req   = fl;
    u_if.new_pc_i    = pc;
    u_if.halt_req    = h;
    u_if.resume_req  = rs;
    #1;
    s_stall = u_if.stall;
    s_flush = u_if.flush;
    s_pc    = u_if.new_pc_o;
    s_state = u_if.state_o;
    s_to    = u_if.timeout_o;
    e_stall = model_stall(r, id, ex, fl, h, rs);
    if (m_valid) begin
      chk("m_stall", 32'(s_stall), 32'(e_stall));
      chk("m_flush", 32'(s_flush), 32'(m_mode == 3));
      chk("m_pc", s_pc, m_pc);
      chk("m_state", 32'(s_state), 32'(m_mode));
      chk("m_timeout", 32'(s_to), 32'(m_to));
      chk("m_stall_cnt", 32'(u_if.stall_cnt_o), 32'(m_perf));
    end
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_to = 1'b0; m_ex_run = 0; m_perf = 0;
      m_valid = 1'b1;
    end else begin
`ifdef CTRL_PERF_CNT_EN
      if (e_stall != 6'h00 && m_perf < 16'hFFFF) m_perf++;
`endif
      if (m_mode == 3) begin
        m_mode = 0;
        m_ex_run = 0;
      end else if (m_mode == 2) begin
        m_ex_run = 0;
        if (fl) begin m_mode = 3; m_pc = pc; end
        else if (rs) m_mode = 0;
      end else begin
        if (fl) begin
          m_mode = 3; m_pc = pc;
        end else if (ex && m_ex_run == LIMIT - 1) begin
          m_mode = 3; m_pc = 32'h0000_0100; m_to = 1'b1;
        end else if (ex || id) begin
          m_mode = 1;
        end else if (h && m_mode == 0) begin
          m_mode = 2;
        end else begin
          m_mode = 0;
        end
        if (ex && !fl) m_ex_run = (m_ex_run < LIMIT) ? m_ex_run + 1 : LIMIT;
        else m_ex_run = 0;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        r, id, ex, fl, h, rs;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic [1:0]  e_state;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_to;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, id, ex, fl, h, rs, input logic [31:0] pc,
                     input logic [5:0] es, input logic [1:0] est, input logic ef,
                     input logic [31:0] epc, input logic eto);
    vec_t v;
    v.r = r; v.id = id; v.ex = ex; v.fl = fl; v.h = h; v.rs = rs; v.pc = pc;
    v.e_stall = es; v.e_state = est; v.e_flush = ef; v.e_pc = epc; v.e_to = eto;
    tbl.push_back(v);
  endtask

  initial begin
    int burst;
    logic id, ex, fl, h, rs, r;
    rst = 1'b1;
    u_if.stallreq_id = 0; u_if.stallreq_ex = 0; u_if.flush_req = 0;
    u_if.new_pc_i = 0; u_if.halt_req = 0; u_if.resume_req = 0;

    //   r  id ex fl h  rs pc            stall  st  fl  new_pc        to
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'h0,         0);
    add(0, 1, 0, 0, 0, 0, 32'h0,         6'h07, 0, 0, 32'h0,         0);
    add(0, 1, 0, 0, 0, 0, 32'h0,         6'h07, 1, 0, 32'h0,         0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 1, 0, 32'h0,         0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'h0,         0);
    add(0, 1, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 0, 32'h0,         0);
    add(0, 1, 1, 0, 0, 0, 32'h0,         6'h0F, 1, 0, 32'h0,         0);
    add(0, 1, 0, 1, 0, 0, 32'hBFC0_0380, 6'h00, 1, 0, 32'h0,         0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 3, 1, 32'hBFC0_0380, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'hBFC0_0380, 0);
    add(0, 0, 0, 0, 1, 0, 32'h0,         6'h00, 0, 0, 32'hBFC0_0380, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 0, 32'h0,       6'h3F, 2, 0, 32'hBFC0_0380, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0,         6'h00, 2, 0, 32'hBFC0_0380, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'hBFC0_0380, 0);
    add(0, 0, 0, 0, 1, 0, 32'h0,         6'h00, 0, 0, 32'hBFC0_0380, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h3F, 2, 0, 32'hBFC0_0380, 0);
    add(1, 1, 1, 1, 1, 0, 32'h0,         6'h00, 2, 0, 32'hBFC0_0380, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'h0,         0);
    add(0, 0, 0, 0, 1, 0, 32'h0,         6'h00, 0, 0, 32'h0,         0);
    add(0, 0, 0, 0, 1, 1, 32'h0,         6'h00, 2, 0, 32'h0,         0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'h0,         0);
    add(0, 0, 0, 1, 0, 0, 32'h1234,      6'h00, 0, 0, 32'h0,         0);
    add(0, 0, 0, 1, 0, 0, 32'h5678,      6'h00, 3, 1, 32'h1234,      0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'h1234,      0);
    add(0, 0, 0, 0, 1, 0, 32'h0,         6'h00, 0, 0, 32'h1234,      0);
    add(0, 0, 0, 1, 0, 0, 32'hAAAA_0000, 6'h00, 2, 0, 32'h1234,      0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 3, 1, 32'hAAAA_0000, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 0, 32'hAAAA_0000, 0);

    @(negedge clk);
    cycle(1, 0, 0, 0, 32'h0, 0, 0);

    // Directed table
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].id, tbl[i].ex, tbl[i].fl, tbl[i].pc, tbl[i].h, tbl[i].rs);
      chk($sformatf("t%0d_stall", i), 32'(s_stall), 32'(tbl[i].e_stall));
      chk($sformatf("t%0d_state", i), 32'(s_state), 32'(tbl[i].e_state));
      chk($sformatf("t%0d_flush", i), 32'(s_flush), 32'(tbl[i].e_flush));
      chk($sformatf("t%0d_pc", i), s_pc, tbl[i].e_pc);
      chk($sformatf("t%0d_to", i), 32'(s_to), 32'(tbl[i].e_to));
    end

    // One cycle short of the limit: no timeout
    for (int i = 1; i <= LIMIT - 1; i++) cycle(0, 0, 1, 0, 32'h0, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    chk("short_flush", 32'(s_flush), 32'd0);
    chk("short_to", 32'(s_to), 32'd0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);

    // Full limit: timeout flush on the cycle after the last held one
    for (int i = 1; i <= LIMIT; i++) begin
      cycle(0, 0, 1, 0, 32'h0, 0, 0);
      if (i == LIMIT - 1) chk("to_pre_stall", 32'(s_stall), 32'h0F);
      if (i == LIMIT) begin
        chk("to_hit_stall", 32'(s_stall), 32'h00);
        chk("to_hit_state", 32'(s_state), 32'd1);
      end
    end
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    chk("to_flush", 32'(s_flush), 32'd1);
    chk("to_pc", s_pc, 32'h0000_0100);
    chk("to_flag", 32'(s_to), 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 32'h0, 0, 0);
    chk("to_sticky", 32'(s_to), 32'd1);
    cycle(1, 0, 0, 0, 32'h0, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 0);
    chk("to_rst_clear", 32'(s_to), 32'd0);
    chk("to_rst_pc", s_pc, 32'h0);

    // Randomized traffic with occasional long stallreq_ex bursts
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(55, 75);
      r  = ($urandom_range(0, 199) == 0);
      id = ($urandom_range(0, 9) < 3);
      ex = (burst > 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 29) == 0);
      h  = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 4) == 0);
      if (burst > 0) burst--;
      cycle(r, id, ex, fl, $urandom, h, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
